result_formatter: RTL

RESULT_FORMATTER -- requirements
Module: result_formatter

---
 rtl/calc_fmt_pkg.sv | 39 +++
 rtl/bin2bcd_seq.sv | 76 +++++++
 rtl/result_formatter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/calc_fmt_pkg.sv
// Shared definitions for the calculator result formatter.
//   - fmt_state_t   : serializer FSM states
//   - byte_phase_t  : which part of the output line is being emitted
//   - ASCII constants, digit count and a digit-to-ASCII helper
package calc_fmt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CONVERT,
    SCAN,
    LOAD,
    SEND,
    GUARD,
    WAIT
  } fmt_state_t;

  // Digits first, then the optional CR/LF trailer.
  typedef enum logic [1:0] {
    PH_DIGITS,
    PH_CR,
    PH_LF
  } byte_phase_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  localparam int NUM_DIGITS = 10;
  localparam int BIN_W      = 32;
  localparam int BCD_W      = 4 * NUM_DIGITS;

  // Index of the most-significant decimal digit.
  localparam logic [3:0] MSD_INDEX = 4'(NUM_DIGITS - 1);

  function automatic logic [7:0] digit_to_ascii(input logic [3:0] d);
    return ASCII_ZERO + {4'h0, d};
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter.
// One shift per clock, 32 shifts in total. The first shift is folded into the
// load cycle (with an all-zero BCD field it is a plain shift), so done rises
// 31 cycles after start and the caller sees exactly 32 cycles from start to
// the cycle in which it consumes done.
// Ports:
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset, clears both shift registers
//   start   : one-cycle pulse, samples bin
//   bin     : 32-bit unsigned input
//   done    : one-cycle pulse, bcd is valid from this cycle on
//   bcd     : 10 packed BCD digits, held until the next start
import calc_fmt_pkg::*;

module bin2bcd_seq (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  logic [BIN_W-1:0] bin_reg;
  logic [BCD_W-1:0] bcd_reg;
  logic [4:0]       cnt_reg;
  logic             active_reg;
  logic             done_reg;

  // Add-3 correction for digits 0..8. The top digit of a 32-bit value never
  // exceeds 4 at any point of the conversion, so it needs no correction.
  logic [4*(NUM_DIGITS-1)-1:0] adj;
  logic [BCD_W-1:0]            bcd_shift;
  logic [BIN_W-1:0]            bin_shift;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS - 1; gi++) begin : g_adj
      assign adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                              (bcd_reg[gi*4 +: 4] + 4'd3) : bcd_reg[gi*4 +: 4];
    end
  endgenerate

  assign bcd_shift = {bcd_reg[BCD_W-2:BCD_W-4], adj, bin_reg[BIN_W-1]};
  assign bin_shift = {bin_reg[BIN_W-2:0], 1'b0};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bin_reg    <= '0;
      bcd_reg    <= '0;
      cnt_reg    <= '0;
      active_reg <= 1'b0;
      done_reg   <= 1'b0;
    end else if (start) begin
      bcd_reg    <= {{(BCD_W-1){1'b0}}, bin[BIN_W-1]};
      bin_reg    <= {bin[BIN_W-2:0], 1'b0};
      cnt_reg    <= 5'd31;
      active_reg <= 1'b1;
      done_reg   <= 1'b0;
    end else if (active_reg) begin
      bcd_reg <= bcd_shift;
      bin_reg <= bin_shift;
      cnt_reg <= cnt_reg - 5'd1;
      if (cnt_reg == 5'd1) begin
        active_reg <= 1'b0;
        done_reg   <= 1'b1;
      end
    end else begin
      done_reg <= 1'b0;
    end
  end

  assign done = done_reg;
  assign bcd  = bcd_reg;

endmodule

// File: rtl/result_formatter.sv
// Converts a 32-bit calculator result to decimal ASCII and streams it to a
// UART transmitter, most-significant non-zero digit first, optionally
// followed by CR LF.
// Ports:
//   clk, reset_n  : clock and asynchronous active-low reset
//   result        : value sampled when result_ready is accepted in IDLE
//   result_ready  : one-cycle valid pulse
//   tx_busy       : transmitter busy
//   tx_data       : byte to send, held from LOAD to the next LOAD
//   tx_start      : one-cycle transmit request
//   bcd_low       : four low BCD digits of the last completed conversion
//   busy          : high from acceptance until the last byte has gone out
//   overrun       : one-cycle pulse for a result_ready that was dropped
import calc_fmt_pkg::*;

module result_formatter #(
  parameter int APPEND_CRLF  = 1,
  parameter int GUARD_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [BIN_W-1:0] result,
  input  logic             result_ready,
  input  logic             tx_busy,
  output logic [7:0]       tx_data,
  output logic             tx_start,
  output logic [15:0]      bcd_low,
  output logic             busy,
  output logic             overrun
);

  localparam int GUARD_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES + 1) : 1;
  localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(GUARD_CYCLES);

  fmt_state_t   state_reg,  state_next;
  byte_phase_t  phase_reg,  phase_next;
  logic [3:0]   ptr_reg,    ptr_next;
  logic [GUARD_W-1:0] guard_reg, guard_next;
  logic [7:0]   tx_data_reg,  tx_data_next;
  logic         tx_start_reg, tx_start_next;
  logic [15:0]  bcd_low_reg,  bcd_low_next;
  logic         busy_reg,     busy_next;
  logic         overrun_reg,  overrun_next;

  logic             conv_start;
  logic             conv_done;
  logic [BCD_W-1:0] conv_bcd;
  logic [3:0]       digit [NUM_DIGITS];
  logic             last_byte;

  // The converter's binary shift register is the latched copy of result.
  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (conv_start),
    .bin     (result),
    .done    (conv_done),
    .bcd     (conv_bcd)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign digit[gi] = conv_bcd[gi*4 +: 4];
    end
  endgenerate

  // The byte just sent is the final one of the line.
  always_comb begin
    last_byte = 1'b0;
    if (phase_reg == PH_LF)
      last_byte = 1'b1;
    else if (phase_reg == PH_DIGITS && ptr_reg == 4'd0 && APPEND_CRLF == 0)
      last_byte = 1'b1;
  end

  always_comb begin
    state_next    = state_reg;
    phase_next    = phase_reg;
    ptr_next      = ptr_reg;
    guard_next    = guard_reg;
    tx_data_next  = tx_data_reg;
    tx_start_next = 1'b0;
    bcd_low_next  = bcd_low_reg;
    busy_next     = busy_reg;
    conv_start    = 1'b0;
    // Anything arriving outside IDLE is dropped, including the cycle in which
    // WAIT hands back to IDLE.
    overrun_next  = result_ready && (state_reg != IDLE);

    case (state_reg)
      IDLE: begin
        if (result_ready) begin
          conv_start = 1'b1;
          busy_next  = 1'b1;
          state_next = CONVERT;
        end
      end

      CONVERT: begin
        if (conv_done) begin
          bcd_low_next = conv_bcd[15:0];
          ptr_next     = MSD_INDEX;
          phase_next   = PH_DIGITS;
          state_next   = SCAN;
        end
      end

      // Skip leading zeros but never digit 0, so a zero result prints "0".
      SCAN: begin
        if (digit[ptr_reg] == 4'd0 && ptr_reg != 4'd0)
          ptr_next = ptr_reg - 4'd1;
        else
          state_next = LOAD;
      end

      LOAD: begin
        case (phase_reg)
          PH_CR:   tx_data_next = ASCII_CR;
          PH_LF:   tx_data_next = ASCII_LF;
          default: tx_data_next = digit_to_ascii(digit[ptr_reg]);
        endcase
        state_next = SEND;
      end

      SEND: begin
        if (!tx_busy) begin
          tx_start_next = 1'b1;
          guard_next    = GUARD_LOAD;
          state_next    = (GUARD_CYCLES > 0) ? GUARD : WAIT;
        end
      end

      // The transmitter may take a cycle or two to raise tx_busy after
      // tx_start; ignore it here so a stale low is not taken as completion.
      GUARD: begin
        if (guard_reg <= GUARD_W'(1))
          state_next = WAIT;
        else
          guard_next = guard_reg - GUARD_W'(1);
      end

      WAIT: begin
        if (!tx_busy) begin
          if (last_byte) begin
            busy_next  = 1'b0;
            state_next = IDLE;
          end else begin
            state_next = LOAD;
            if (phase_reg == PH_DIGITS) begin
              if (ptr_reg != 4'd0)
                ptr_next = ptr_reg - 4'd1;
              else
                phase_next = PH_CR;
            end else begin
              phase_next = PH_LF;
            end
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      phase_reg    <= PH_DIGITS;
      ptr_reg      <= '0;
      guard_reg    <= '0;
      tx_data_reg  <= 8'h00;
      tx_start_reg <= 1'b0;
      bcd_low_reg  <= 16'h0000;
      busy_reg     <= 1'b0;
      overrun_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      phase_reg    <= phase_next;
      ptr_reg      <= ptr_next;
      guard_reg    <= guard_next;
      tx_data_reg  <= tx_data_next;
      tx_start_reg <= tx_start_next;
      bcd_low_reg  <= bcd_low_next;
      busy_reg     <= busy_next;
      overrun_reg  <= overrun_next;
    end
  end

  assign tx_data  = tx_data_reg;
  assign tx_start = tx_start_reg;
  assign bcd_low  = bcd_low_reg;
  assign busy     = busy_reg;
  assign overrun  = overrun_reg;

endmodule
